vram_write_arbiter: RTL

- Shares the single write port of the 1024×16 dual-port video RAM between two requesters:
  - an external host issuing single-word writes over a valid/ready handshake;
  - an internal fill engine that sweeps all 1024 words with a constant value (screen clear or fill).
- Sits between the host bus logic and the video RAM write port (CE/address/data).
- The read/scan-out port of the RAM is untouched.

---
 rtl/vram_ctrl_pkg.sv | 14 +
 rtl/vram_write_arbiter_if.sv | 30 +++
 rtl/vram_write_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/vram_ctrl_pkg.sv
// rtl/vram_ctrl_pkg.sv - shared video RAM controller constants and arbiter state type
package vram_ctrl_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 16;
  localparam int VRAM_DEPTH  = 1024;

  // Write-port arbiter state, shared with future scan-out/sprite controllers
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// rtl/vram_write_arbiter_if.sv - host single-word write handshake into the VRAM arbiter
interface vram_write_arbiter_if
  import vram_ctrl_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;

  // Host bus logic drives requests
  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  // Arbiter accepts requests
  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );

endinterface

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - shares the VRAM write port between host writes and a screen fill engine
module vram_write_arbiter
  import vram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = VRAM_ADDR_W,
  parameter int DATA_W         = VRAM_DATA_W,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vram_write_arbiter_if.slave  host,
  input  logic                 fill_start,
  input  logic                 fill_abort,
  input  logic [DATA_W-1:0]    fill_value,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic                 ram_ce,
  output logic [ADDR_W-1:0]    ram_ad,
  output logic [DATA_W-1:0]    ram_di
);

  localparam int                  STREAK_W   = $clog2(HOST_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HOST_BURST_MAX);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = '1;

  arb_state_e          state;
  logic [ADDR_W-1:0]   fill_ptr;
  logic [DATA_W-1:0]   fill_val;
  logic [STREAK_W-1:0] streak;
  logic                host_ready_int;
  logic                host_xfer;

  // Host may go whenever no fill runs, or while its burst allowance lasts;
  // depends on registered state only so the host never sees a comb loop
  always_comb begin
    host_ready_int = (state == IDLE) || (streak < STREAK_MAX);
    host_xfer      = host.host_valid && host_ready_int;
  end

  assign host.host_ready = host_ready_int;

  // Slot arbitration, fill sequencer and registered RAM write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fill_ptr  <= '0;
      fill_val  <= '0;
      streak    <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
      ram_ce    <= 1'b0;
      ram_ad    <= '0;
      ram_di    <= '0;
    end else begin
      ram_ce    <= 1'b0;
      fill_done <= 1'b0;

      // A granted host write always lands, including on an abort cycle
      if (host_xfer) begin
        ram_ce <= 1'b1;
        ram_ad <= host.host_addr;
        ram_di <= host.host_data;
      end

      case (state)
        IDLE: begin
          // Abort in the same cycle cancels the start request
          if (fill_start && !fill_abort) begin
            state     <= FILL;
            fill_val  <= fill_value;
            fill_ptr  <= '0;
            streak    <= '0;
            fill_busy <= 1'b1;
          end
        end

        FILL: begin
          if (fill_abort) begin
            state     <= IDLE;
            streak    <= '0;
            fill_busy <= 1'b0;
          end else if (host_xfer) begin
            if (streak < STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else begin
            // Slot not taken by the host belongs to the fill engine
            ram_ce   <= 1'b1;
            ram_ad   <= fill_ptr;
            ram_di   <= fill_val;
            fill_ptr <= fill_ptr + 1'b1;
            streak   <= '0;
            if (fill_ptr == LAST_ADDR) begin
              state     <= IDLE;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
